// File: rtl/button_conditioner.sv
// Multi-channel push-button conditioner: synchronizer, tick-sampled saturating
// integrator, and per-channel RELEASED/PRESSED/HELD FSM with registered outputs.
// Optional auto-repeat pulses in HELD are built when BUTTON_CONDITIONER_REPEAT_EN
// is defined; otherwise repeat_pulse is tied to 0.
module button_conditioner #(
    parameter int unsigned WIDTH          = 1,
    parameter int unsigned SAMPLE_CNT_MAX = 25000,
    parameter int unsigned PULSE_CNT_MAX  = 150,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned HOLD_CNT_MAX   = 500,
    parameter int unsigned REPEAT_CNT_MAX = 100
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] glitchy_signal,
    output logic [WIDTH-1:0] debounced_signal,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic [WIDTH-1:0] long_press,
    output logic [WIDTH-1:0] repeat_pulse
);

    localparam int unsigned TICK_W = $clog2(SAMPLE_CNT_MAX) + 1;
    localparam int unsigned CNT_W  = $clog2(PULSE_CNT_MAX + 1) + 1;
    localparam int unsigned HOLD_W = $clog2(HOLD_CNT_MAX + 1) + 1;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLE_CNT_MAX - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(PULSE_CNT_MAX);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_CNT_MAX);

    typedef enum logic [1:0] {
        ST_RELEASED = 2'd0,
        ST_PRESSED  = 2'd1,
        ST_HELD     = 2'd2
    } state_t;

    // Reject configurations the counters cannot represent
    if (SAMPLE_CNT_MAX < 1 || PULSE_CNT_MAX < 1 || SYNC_STAGES < 2 ||
        HOLD_CNT_MAX < 1 || REPEAT_CNT_MAX < 1) begin : g_param_check
        $error("button_conditioner: illegal parameter value");
    end

    logic [TICK_W-1:0] tick_cnt;
    logic              tick_c;

    assign tick_c = (tick_cnt == TICK_LAST);

    // Shared free-running sample tick counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
        end else if (tick_c) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TICK_W'(1);
        end
    end

    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   sample;
        logic [CNT_W-1:0]       cnt_q;
        logic [CNT_W-1:0]       cnt_d;
        logic [HOLD_W-1:0]      hold_q;
        logic [HOLD_W-1:0]      hold_d;
        state_t                 state_q;
        state_t                 state_d;
        logic                   deb_d;
        logic                   rise_d;
        logic                   fall_d;
        logic                   long_d;
        logic                   deb_q;
        logic                   rise_q;
        logic                   fall_q;
        logic                   long_q;

        assign sample = sync_q[SYNC_STAGES-1];

        // Metastability synchronizer for the raw pin
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync_q <= '0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], glitchy_signal[i]};
            end
        end

        // Saturating up/down integrator, advanced only on the sample tick
        always_comb begin
            cnt_d = cnt_q;
            if (tick_c) begin
                if (sample && (cnt_q < CNT_MAX)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else if (!sample && (cnt_q != '0)) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
        end

        // State, integrator and hold counter registers
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= ST_RELEASED;
                cnt_q   <= '0;
                hold_q  <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                hold_q  <= hold_d;
            end
        end

        // Next-state: transitions judged on the post-tick integrator value;
        // release wins over the hold timeout on the same tick
        always_comb begin
            state_d = state_q;
            hold_d  = hold_q;
            if (tick_c) begin
                case (state_q)
                    ST_RELEASED: begin
                        if (cnt_d == CNT_MAX) begin
                            state_d = ST_PRESSED;
                            hold_d  = '0;
                        end
                    end
                    ST_PRESSED: begin
                        if (hold_q != HOLD_MAX) begin
                            hold_d = hold_q + HOLD_W'(1);
                        end
                        if (cnt_d == '0) begin
                            state_d = ST_RELEASED;
                        end else if (hold_d == HOLD_MAX) begin
                            state_d = ST_HELD;
                        end
                    end
                    ST_HELD: begin
                        if (cnt_d == '0) begin
                            state_d = ST_RELEASED;
                        end
                    end
                    default: begin
                        state_d = ST_RELEASED;
                    end
                endcase
            end
        end

        // Output decode from the transition being taken this cycle
        always_comb begin
            deb_d  = 1'b0;
            rise_d = 1'b0;
            fall_d = 1'b0;
            long_d = 1'b0;
            deb_d  = (state_d != ST_RELEASED);
            rise_d = (state_q == ST_RELEASED) && (state_d == ST_PRESSED);
            fall_d = (state_q != ST_RELEASED) && (state_d == ST_RELEASED);
            long_d = (state_d == ST_HELD);
        end

        // Registered outputs, aligned with the state change
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                deb_q  <= 1'b0;
                rise_q <= 1'b0;
                fall_q <= 1'b0;
                long_q <= 1'b0;
            end else begin
                deb_q  <= deb_d;
                rise_q <= rise_d;
                fall_q <= fall_d;
                long_q <= long_d;
            end
        end

        assign debounced_signal[i] = deb_q;
        assign rise_pulse[i]       = rise_q;
        assign fall_pulse[i]       = fall_q;
        assign long_press[i]       = long_q;

`ifdef BUTTON_CONDITIONER_REPEAT_EN
        localparam int unsigned REP_W = $clog2(REPEAT_CNT_MAX + 1) + 1;
        localparam logic [REP_W-1:0] REP_MAX = REP_W'(REPEAT_CNT_MAX);

        logic [REP_W-1:0] rep_q;
        logic [REP_W-1:0] rep_d;
        logic             rep_pulse_d;
        logic             rep_pulse_q;

        // Repeat timer: pulse on HELD entry, then every REPEAT_CNT_MAX ticks
        always_comb begin
            rep_d       = '0;
            rep_pulse_d = 1'b0;
            if (state_d == ST_HELD) begin
                if (state_q != ST_HELD) begin
                    rep_pulse_d = 1'b1;
                end else if (tick_c) begin
                    if ((rep_q + REP_W'(1)) == REP_MAX) begin
                        rep_pulse_d = 1'b1;
                    end else begin
                        rep_d = rep_q + REP_W'(1);
                    end
                end else begin
                    rep_d = rep_q;
                end
            end
        end

        // Repeat counter and pulse registers
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rep_q       <= '0;
                rep_pulse_q <= 1'b0;
            end else begin
                rep_q       <= rep_d;
                rep_pulse_q <= rep_pulse_d;
            end
        end

        assign repeat_pulse[i] = rep_pulse_q;
`else
        assign repeat_pulse[i] = 1'b0;
`endif
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner: a tick-level behavioural model
// predicts every cycle's outputs into a queue; a negedge monitor compares.
module tb_button_conditioner;

    localparam int unsigned WIDTH = 2;
    localparam int unsigned SMAX  = 4;
    localparam int unsigned PMAX  = 3;
    localparam int unsigned SYNC  = 2;
    localparam int unsigned HMAX  = 5;
    localparam int unsigned RMAX  = 2;
`ifdef BUTTON_CONDITIONER_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    typedef struct packed {
        logic [WIDTH-1:0] deb;
        logic [WIDTH-1:0] rise;
        logic [WIDTH-1:0] fall;
        logic [WIDTH-1:0] lng;
        logic [WIDTH-1:0] rep;
    } obs_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] glitchy_signal;
    logic [WIDTH-1:0] debounced_signal;
    logic [WIDTH-1:0] rise_pulse;
    logic [WIDTH-1:0] fall_pulse;
    logic [WIDTH-1:0] long_press;
    logic [WIDTH-1:0] repeat_pulse;

    int n_checks = 0;
    int n_fail   = 0;

    obs_t exp_q[$];

    // model state: pipeline of raw samples, integrator level, press age in ticks
    int m_tick;
    bit m_pipe [WIDTH][SYNC];
    int m_level [WIDTH];
    bit m_on [WIDTH];
    int m_age [WIDTH];

    // observed pulse statistics from the stimulus side
    int rise_cnt [WIDTH];
    int fall_cnt [WIDTH];
    int rep_cnt [WIDTH];
    int deb_cyc [WIDTH];

    button_conditioner #(
        .WIDTH          (WIDTH),
        .SAMPLE_CNT_MAX (SMAX),
        .PULSE_CNT_MAX  (PMAX),
        .SYNC_STAGES    (SYNC),
        .HOLD_CNT_MAX   (HMAX),
        .REPEAT_CNT_MAX (RMAX)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .glitchy_signal   (glitchy_signal),
        .debounced_signal (debounced_signal),
        .rise_pulse       (rise_pulse),
        .fall_pulse       (fall_pulse),
        .long_press       (long_press),
        .repeat_pulse     (repeat_pulse)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic check_range(input string name, input int got, input int lo, input int hi);
        n_checks++;
        if (got < lo || got > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d..%0d at %0t", name, got, lo, hi, $time);
        end
    endtask

    task automatic model_reset();
        m_tick = 0;
        for (int c = 0; c < int'(WIDTH); c++) begin
            for (int k = 0; k < int'(SYNC); k++) m_pipe[c][k] = 1'b0;
            m_level[c] = 0;
            m_on[c]    = 1'b0;
            m_age[c]   = 0;
        end
    endtask

    // One clock edge of the behavioural model; pushes the outputs seen after it
    task automatic model_step();
        obs_t o;
        bit   tk;
        bit   s;
        o  = '0;
        tk = (m_tick == int'(SMAX) - 1);
        for (int c = 0; c < int'(WIDTH); c++) begin
            s = m_pipe[c][SYNC-1];
            if (tk) begin
                if (s && m_level[c] < int'(PMAX)) m_level[c]++;
                else if (!s && m_level[c] > 0) m_level[c]--;
                if (!m_on[c]) begin
                    if (m_level[c] == int'(PMAX)) begin
                        m_on[c]  = 1'b1;
                        m_age[c] = 0;
                        o.rise[c] = 1'b1;
                    end
                end else if (m_level[c] == 0) begin
                    m_on[c]   = 1'b0;
                    o.fall[c] = 1'b1;
                end else begin
                    m_age[c]++;
                    if (REP_EN && m_age[c] == int'(HMAX)) o.rep[c] = 1'b1;
                    if (REP_EN && m_age[c] > int'(HMAX) &&
                        ((m_age[c] - int'(HMAX)) % int'(RMAX)) == 0) o.rep[c] = 1'b1;
                end
            end
            o.deb[c] = m_on[c];
            o.lng[c] = m_on[c] && (m_age[c] >= int'(HMAX));
            for (int k = int'(SYNC) - 1; k > 0; k--) m_pipe[c][k] = m_pipe[c][k-1];
            m_pipe[c][0] = glitchy_signal[c];
        end
        m_tick = tk ? 0 : m_tick + 1;
        exp_q.push_back(o);
    endtask

    // Model process: follows clock edges and asynchronous reset
    initial begin
        bit prev_rst;
        prev_rst = 1'b0;
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n or posedge rst_n);
            if (!rst_n) begin
                model_reset();
                exp_q.delete();
            end else if (!prev_rst) begin
                exp_q.push_back('0);
            end else begin
                model_step();
            end
            prev_rst = rst_n;
        end
    end

    // Monitor: compare DUT outputs against the predicted queue on each falling edge
    always @(negedge clk) begin
        obs_t got;
        got = {debounced_signal, rise_pulse, fall_pulse, long_press, repeat_pulse};
        if (!rst_n) begin
            check("outputs_in_reset", 32'(got), 32'(0));
        end else if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_underflow: got 0x%0h expected a queued prediction at %0t",
                     got, $time);
        end else begin
            check("scoreboard", 32'(got), 32'(exp_q.pop_front()));
        end
    end

    task automatic clear_stats();
        for (int c = 0; c < int'(WIDTH); c++) begin
            rise_cnt[c] = 0;
            fall_cnt[c] = 0;
            rep_cnt[c]  = 0;
            deb_cyc[c]  = 0;
        end
    endtask

    // Advance one cycle; sample just after the edge and accumulate pulse stats
    task automatic step();
        @(posedge clk);
        #1;
        for (int c = 0; c < int'(WIDTH); c++) begin
            rise_cnt[c] += int'(rise_pulse[c]);
            fall_cnt[c] += int'(fall_pulse[c]);
            rep_cnt[c]  += int'(repeat_pulse[c]);
            deb_cyc[c]  += int'(debounced_signal[c]);
        end
    endtask

    function automatic logic pick(input int which, input int ch);
        case (which)
            0:       return debounced_signal[ch];
            1:       return long_press[ch];
            default: return rise_pulse[ch];
        endcase
    endfunction

    // Bounded wait for an output bit to reach a value
    task automatic wait_sig(input int which, input int ch, input logic val, input int limit,
                            output int n, output bit found);
        n     = 0;
        found = 1'b0;
        while (!found && n < limit) begin
            step();
            n++;
            if (pick(which, ch) == val) found = 1'b1;
        end
    endtask

    initial begin
        int n;
        bit found;
        rst_n          = 1'b0;
        glitchy_signal = '0;
        clear_stats();

        // reset with random inputs
        repeat (6) begin
            glitchy_signal = WIDTH'($urandom);
            step();
        end
        check("reset_outputs", 32'({debounced_signal, rise_pulse, fall_pulse, long_press,
                                    repeat_pulse}), 32'(0));
        glitchy_signal = '0;
        rst_n = 1'b1;
        clear_stats();
        repeat (40) step();
        check("idle_activity", 32'(deb_cyc[0] + deb_cyc[1] + rise_cnt[0] + rise_cnt[1] +
                                   fall_cnt[0] + fall_cnt[1]), 32'(0));

        // clean press on ch0
        clear_stats();
        glitchy_signal[0] = 1'b1;
        wait_sig(0, 0, 1'b1, 40, n, found);
        check("press_seen", 32'(found), 32'(1));
        check_range("press_latency", n, int'(SYNC + (PMAX - 1) * SMAX + 1),
                    int'(SYNC + PMAX * SMAX + 1));
        check("rise_aligned", 32'(rise_pulse[0]), 32'(1));

        // release bounce straight out of PRESSED
        glitchy_signal[0] = 1'b0;
        step();
        check("rise_one_cycle", 32'(rise_pulse[0]), 32'(0));
        repeat (7) step();
        glitchy_signal[0] = 1'b1;
        repeat (16) step();
        check("bounce_no_fall", 32'(fall_cnt[0]), 32'(0));
        check("bounce_level", 32'(debounced_signal[0]), 32'(1));
        check("ch1_quiet", 32'(deb_cyc[1] + rise_cnt[1] + fall_cnt[1]), 32'(0));

        // real release
        glitchy_signal[0] = 1'b0;
        wait_sig(0, 0, 1'b0, 40, n, found);
        check("release_seen", 32'(found), 32'(1));
        check("fall_aligned", 32'(fall_pulse[0]), 32'(1));
        step();
        check("fall_one_cycle", 32'(fall_pulse[0]), 32'(0));
        check("fall_count", 32'(fall_cnt[0]), 32'(1));

        // press glitch of two ticks on ch0
        repeat (8) step();
        clear_stats();
        glitchy_signal[0] = 1'b1;
        repeat (8) step();
        glitchy_signal[0] = 1'b0;
        repeat (30) step();
        check("glitch_no_level", 32'(deb_cyc[0]), 32'(0));
        check("glitch_no_pulse", 32'(rise_cnt[0] + fall_cnt[0]), 32'(0));

        // long press on ch1
        clear_stats();
        glitchy_signal[1] = 1'b1;
        wait_sig(1, 1, 1'b1, 80, n, found);
        check("long_seen", 32'(found), 32'(1));
        check_range("long_latency", n, int'(SYNC + (PMAX + HMAX - 1) * SMAX + 1),
                    int'(SYNC + (PMAX + HMAX) * SMAX + 1));
        repeat (24) step();
        check("repeat_count", 32'(rep_cnt[1]), REP_EN ? 32'(4) : 32'(0));
        glitchy_signal[1] = 1'b0;
        clear_stats();
        wait_sig(0, 1, 1'b0, 40, n, found);
        check("long_release_seen", 32'(found), 32'(1));
        check("long_drops_with_level", 32'(long_press[1]), 32'(0));
        check("long_fall_aligned", 32'(fall_pulse[1]), 32'(1));
        step();
        check("long_fall_count", 32'(fall_cnt[1]), 32'(1));

        // reset in the middle of HELD, no clock edge involved
        repeat (8) step();
        glitchy_signal[1] = 1'b1;
        wait_sig(1, 1, 1'b1, 80, n, found);
        check("held_again", 32'(found), 32'(1));
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_clears", 32'({debounced_signal, rise_pulse, fall_pulse, long_press,
                                        repeat_pulse}), 32'(0));
        repeat (3) step();
        rst_n = 1'b1;
        wait_sig(2, 1, 1'b1, 40, n, found);
        check("rerise_seen", 32'(found), 32'(1));
        check_range("rerise_latency", n, int'(PMAX * SMAX), int'(SYNC + PMAX * SMAX + 1));

        // randomized segments: long holds mixed with short chatter
        for (int seg = 0; seg < 70; seg++) begin
            glitchy_signal = WIDTH'($urandom);
            if (seg % 3 == 2) repeat ($urandom_range(1, 6)) step();
            else repeat ($urandom_range(1, 48)) step();
        end
        glitchy_signal = '0;
        repeat (60) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time bound
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
Multi-channel debouncer and edge/long-press detector for board push-buttons and switches, placed between raw I/O pins and the MMIO/user logic.
- Each channel is synchronized, then integrated by a symmetric up/down saturating counter sampled on a shared slow tick, so both press and release are debounced (hysteresis).
- A per-channel FSM produces the debounced level, one-cycle rise/fall pulses and a long-press flag.

Parameters:
- WIDTH, 1: number of independent channels.
- SAMPLE_CNT_MAX, 25000: clk cycles per sample tick; must be ≥1, and 1 gives a tick every cycle.
- PULSE_CNT_MAX, 150: integrator saturation value, in ticks; must be ≥1.
- SYNC_STAGES, 2: synchronizer flops per channel; must be ≥2.
- HOLD_CNT_MAX, 500: ticks spent in PRESSED before entering HELD; must be ≥1.
- REPEAT_CNT_MAX, 100: ticks between auto-repeat pulses while HELD. Used only with the macro.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- glitchy_signal  in  WIDTH  raw asynchronous inputs.
- debounced_signal  out  WIDTH  debounced level; high in PRESSED or HELD.
- rise_pulse  out  WIDTH  one-cycle pulse on entry to PRESSED.
- fall_pulse  out  WIDTH  one-cycle pulse on return to RELEASED.
- long_press  out  WIDTH  high while in HELD.
- repeat_pulse  out  WIDTH  auto-repeat pulses; constant 0 without the macro.

Behaviour:
- One clock (clk). Reset is asynchronous and active-low (rst_n). Assertion immediately clears:
  - all synchronizer flops, the tick counter, integrators, hold/repeat counters;
  - FSMs to RELEASED;
  - every output to 0.
  Deassertion is assumed synchronous to clk at board level.
- Synchronizer: s[i] = glitchy_signal[i] delayed by SYNC_STAGES flops.
- Tick counter, shared, width $clog2(SAMPLE_CNT_MAX)+1:
  - free-runs 0..SAMPLE_CNT_MAX-1 and wraps to 0;
  - tick is combinational, = (count == SAMPLE_CNT_MAX-1).
- Integrator cnt[i], range 0..PULSE_CNT_MAX, width $clog2(PULSE_CNT_MAX+1)+1. Updates only on tick:
  - s=1 and cnt<MAX: cnt+1;
  - s=0 and cnt>0: cnt−1;
  - otherwise hold. Never wraps.
- FSM per channel. States RELEASED, PRESSED, HELD; all transitions occur at the tick clock edge and are evaluated on the next-cnt value.
  - RELEASED→PRESSED when next cnt == PULSE_CNT_MAX. Clears hold counter; rise_pulse=1 for the following cycle only.
  - PRESSED: hold counter +1 per tick, saturating.
    - When the hold counter reaches HOLD_CNT_MAX and next cnt ≠ 0, go to HELD.
    - PRESSED→RELEASED when next cnt == 0; fall_pulse=1 for one cycle.
  - HELD→RELEASED when next cnt == 0; fall_pulse=1 for one cycle.
  - Release takes priority over the hold transition on the same tick.
- Output timing: debounced_signal, rise_pulse, fall_pulse and long_press are all registered. They change in the cycle after the transition edge, and rise_pulse coincides with debounced_signal going high.
- Latency: a clean step is seen after SYNC_STAGES cycles, then PULSE_CNT_MAX ticks.
  - Worst case from input edge to output: SYNC_STAGES + PULSE_CNT_MAX·SAMPLE_CNT_MAX + 1 cycles.
  - Release latency is symmetric.
- Input toggling with less than PULSE_CNT_MAX net ticks in one direction never changes the state.
- Channels are fully independent; no cross-channel interaction apart from the shared tick.

Optional Feature:
Macro BUTTON_CONDITIONER_REPEAT_EN.
- Defined: a per-channel repeat counter runs while in HELD.
  - repeat_pulse is 1 for one cycle on entry to HELD.
  - It then pulses once every REPEAT_CNT_MAX ticks while in HELD.
  - The repeat counter is cleared when leaving HELD.
- Undefined: repeat_pulse is tied to 0 and the repeat counter logic is absent.

Test Plan:
All scenarios use WIDTH=2, SAMPLE_CNT_MAX=4, PULSE_CNT_MAX=3, SYNC_STAGES=2, HOLD_CNT_MAX=5, REPEAT_CNT_MAX=2.
1. Reset: hold rst_n=0 with random inputs → all outputs 0. Release reset with inputs at 0 for 40 cycles → outputs stay 0.
2. Clean press: ch0 held at 1 → debounced_signal[0] rises within 2+12+1 cycles. rise_pulse[0] is high exactly 1 cycle, aligned with it. ch1 outputs stay 0.
3. Press glitch: ch0 high for 2 ticks (8 cycles) then low → integrator peaks at 2 and returns to 0. No debounced_signal and no pulses.
4. Release bounce: from PRESSED, drop low for 2 ticks then high → stays 1, no fall_pulse. Then low for 3 ticks → debounced_signal falls and fall_pulse is high for exactly 1 cycle.
5. Long press: hold ch1 for 3+5 ticks → long_press[1] rises. Keep holding 6 more ticks:
   - with the macro, repeat_pulse[1] gives 4 one-cycle pulses (entry plus every 2 ticks);
   - without the macro, it stays 0.
   Then release for 3 ticks → long_press and debounced_signal drop together with a single fall_pulse.
6. Mid-HELD reset: assert rst_n with no clk edge → all outputs 0 immediately. After deassertion, with input held, rise_pulse requires a full 3 ticks again.
